// File: rtl/memory_controller.sv
// Bridges the MEM stage to a word-wide, byte-enabled data memory: formats stores and loads,
// runs the enable/Ack handshake, stalls the pipeline, and reports misaligned and timed-out accesses.
module memory_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic        Stall,
    output logic [31:0] DataOut,
    output logic        AddressError,
    output logic        BusError,
    output logic [31:0] M_Address,
    output logic [31:0] M_WriteData,
    output logic        M_WriteEnable,
    output logic        M_ReadEnable,
    output logic [3:0]  M_ByteEnable,
    input  logic        M_Ack,
    input  logic [31:0] M_ReadData,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q;
    logic [31:0] dout_q;
    logic        berr_q;
    logic [31:0] maddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        re_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic        is_wr_q;
    logic [7:0]  cnt_q;

    logic        req;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        accept;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  cnt_d;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] fmt_d;

    // Request decode: byte enables and lane-replicated store data, big-endian lanes.
    always_comb begin
        req        = MemRead | MemWrite;
        is_byte    = (Size == 2'b00);
        is_half    = (Size == 2'b01);
        misaligned = is_half ? Address[0] : (!is_byte && (Address[1:0] != 2'b00));
        accept     = (state_q == S_IDLE) && req && !misaligned;
        be_d       = 4'b1111;
        wdata_d    = DataIn;
        if (is_byte) begin
            be_d    = 4'b1000 >> Address[1:0];
            wdata_d = {4{DataIn[7:0]}};
        end else if (is_half) begin
            be_d    = Address[1] ? 4'b0011 : 4'b1100;
            wdata_d = {2{DataIn[15:0]}};
        end
    end

    // Load formatting uses the size/offset latched at accept, not the live pipeline inputs.
    always_comb begin
        case (off_q)
            2'd0:    lane_b = M_ReadData[31:24];
            2'd1:    lane_b = M_ReadData[23:16];
            2'd2:    lane_b = M_ReadData[15:8];
            default: lane_b = M_ReadData[7:0];
        endcase
        lane_h = off_q[1] ? M_ReadData[15:0] : M_ReadData[31:16];
        case (size_q)
            2'b00:   fmt_d = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   fmt_d = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: fmt_d = M_ReadData;
        endcase
        cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            dout_q  <= 32'h0;
            berr_q  <= 1'b0;
            maddr_q <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            is_wr_q <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_REQ;
                        maddr_q <= {Address[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        size_q  <= Size;
                        off_q   <= Address[1:0];
                        uns_q   <= Unsigned;
                        is_wr_q <= MemWrite;
                        we_q    <= MemWrite;
                        re_q    <= ~MemWrite;
                    end
                end
                S_REQ: begin
                    we_q    <= 1'b0;
                    re_q    <= 1'b0;
                    cnt_q   <= 8'h0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (M_Ack) begin
                        if (!is_wr_q) begin
                            dout_q <= fmt_d;
                        end
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TIMEOUT_C) begin
                            berr_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    // The request is still on the inputs here; it is deliberately not re-issued.
                    berr_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Stall         = accept || (state_q == S_REQ) || (state_q == S_WAIT);
    assign AddressError  = (state_q == S_IDLE) && req && misaligned;
    assign DataOut       = dout_q;
    assign BusError      = berr_q;
    assign M_Address     = maddr_q;
    assign M_WriteData   = wdata_q;
    assign M_WriteEnable = we_q;
    assign M_ReadEnable  = re_q;
    assign M_ByteEnable  = be_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: a byte-enabled memory model answers the handshake,
// the driver queues expected completions and a monitor checks each completed access.
module tb_memory_controller;
  localparam int TIMEOUT = 15;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic        CLK;
  logic        RST;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        Stall;
  logic [31:0] DataOut;
  logic        AddressError;
  logic        BusError;
  logic [31:0] M_Address;
  logic [31:0] M_WriteData;
  logic        M_WriteEnable;
  logic        M_ReadEnable;
  logic [3:0]  M_ByteEnable;
  logic        M_Ack;
  logic [31:0] M_ReadData;
  logic [1:0]  dbg_state;

  memory_controller #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .DataIn(DataIn), .Stall(Stall),
    .DataOut(DataOut), .AddressError(AddressError), .BusError(BusError),
    .M_Address(M_Address), .M_WriteData(M_WriteData), .M_WriteEnable(M_WriteEnable),
    .M_ReadEnable(M_ReadEnable), .M_ByteEnable(M_ByteEnable), .M_Ack(M_Ack),
    .M_ReadData(M_ReadData), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // memory model: Ack one cycle after an enable, byte-enabled writes
  logic [31:0] mem [0:63];
  logic        ack_off;
  logic        mem_init;
  always @(posedge CLK) begin
    M_Ack <= 1'b0;
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[8] <= 32'hAABBCCDD;
    end else if (!ack_off && (M_ReadEnable || M_WriteEnable)) begin
      M_Ack <= 1'b1;
      M_ReadData <= mem[M_Address[7:2]];
      if (M_WriteEnable)
        for (int b = 0; b < 4; b++)
          if (M_ByteEnable[b]) mem[M_Address[7:2]][8*b +: 8] <= M_WriteData[8*b +: 8];
    end
  end

  // scoreboard
  typedef struct packed {
    logic [31:0] dout;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  stall_cyc;
    logic [1:0]  rd_en;
    logic [1:0]  wr_en;
    logic        berr;
    logic        aerr;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] dout, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [7:0] stall_cyc, input logic [1:0] rd_en,
                              input logic [1:0] wr_en, input logic berr, input logic aerr);
    exp_t e;
    e.dout = dout; e.addr = addr; e.wdata = wdata; e.be = be; e.stall_cyc = stall_cyc;
    e.rd_en = rd_en; e.wr_en = wr_en; e.berr = berr; e.aerr = aerr;
    return e;
  endfunction

  // monitor: accumulates per-request activity, compares when Stall drops
  int          stall_cnt, rd_cnt, wr_cnt, berr_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  exp_t        mon_e;
  always @(negedge CLK) begin
    if (RST || !(MemRead || MemWrite)) begin
      stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; berr_cnt = 0;
    end else begin
      if (Stall) stall_cnt++;
      if (M_ReadEnable) rd_cnt++;
      if (M_WriteEnable) wr_cnt++;
      if (M_ReadEnable || M_WriteEnable) begin
        cap_addr = M_Address; cap_wdata = M_WriteData; cap_be = M_ByteEnable;
      end
      if (BusError) berr_cnt++;
      if (!Stall) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data_out", DataOut, mon_e.dout);
          chk("address_error", {31'd0, AddressError}, {31'd0, mon_e.aerr});
          chk("bus_error_pulses", berr_cnt, {31'd0, mon_e.berr});
          chk("stall_cycles", stall_cnt, {24'd0, mon_e.stall_cyc});
          chk("read_enable_cycles", rd_cnt, {30'd0, mon_e.rd_en});
          chk("write_enable_cycles", wr_cnt, {30'd0, mon_e.wr_en});
          if (mon_e.rd_en != 2'd0 || mon_e.wr_en != 2'd0) begin
            chk("m_address", cap_addr, mon_e.addr);
            chk("m_write_data", cap_wdata, mon_e.wdata);
            chk("m_byte_enable", {28'd0, cap_be}, {28'd0, mon_e.be});
          end
        end
        stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; berr_cnt = 0;
      end
    end
  end

  // driver: called just after a rising edge, returns just after a rising edge
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] din, input exp_t e);
    int n;
    exp_q.push_back(e);
    MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Address = addr; DataIn = din;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (Stall && n < 40);
    if (Stall) begin
      chk("completion_timeout", 32'd1, 32'd0);
      void'(exp_q.pop_front());
    end
    @(posedge CLK);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0; DataIn = 32'h0;
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                    input logic [3:0] be, input logic [31:0] dout);
    issue(1'b1, 1'b0, sz, uns, addr, 32'h0,
          mk(dout, {addr[31:2], 2'b00}, 32'h0, be, 8'd3, 2'd1, 2'd0, 1'b0, 1'b0));
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] din,
                    input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] dout);
    issue(1'b0, 1'b1, sz, 1'b0, addr, din,
          mk(dout, {addr[31:2], 2'b00}, wdata, be, 8'd3, 2'd0, 2'd1, 1'b0, 1'b0));
  endtask

  task automatic bad(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] dout);
    issue(rd, wr, sz, 1'b0, addr, 32'h0,
          mk(dout, 32'h0, 32'h0, 4'h0, 8'd0, 2'd0, 2'd0, 1'b0, 1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; mem_init = 1'b1; ack_off = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00; Unsigned = 1'b0;
    Address = 32'h0; DataIn = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0; mem_init = 1'b0;
    @(negedge CLK);
    chk("reset_stall", {31'd0, Stall}, 32'd0);
    chk("reset_data_out", DataOut, 32'h0);
    chk("reset_bus_error", {31'd0, BusError}, 32'd0);
    chk("reset_enables", {30'd0, M_WriteEnable, M_ReadEnable}, 32'd0);
    chk("reset_byte_enable", {28'd0, M_ByteEnable}, 32'd0);
    chk("reset_m_address", M_Address, 32'h0);
    chk("reset_m_write_data", M_WriteData, 32'h0);
    chk("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(posedge CLK);
    #1;

    // word store/load round trip
    st(2'b10, 32'h8, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
    ld(2'b10, 1'b0, 32'h8, 4'b1111, 32'hDEADBEEF);
    // byte lane 1, signed and unsigned
    st(2'b00, 32'h11, 32'h00000080, 4'b0100, 32'h80808080, 32'hDEADBEEF);
    ld(2'b00, 1'b0, 32'h11, 4'b0100, 32'hFFFFFF80);
    ld(2'b00, 1'b1, 32'h11, 4'b0100, 32'h00000080);
    // halfword into the low lane of 0xAABBCCDD
    st(2'b01, 32'h22, 32'h00001234, 4'b0011, 32'h12341234, 32'h00000080);
    chk("mem_after_sh", mem[8], 32'hAABB1234);
    ld(2'b01, 1'b0, 32'h20, 4'b1100, 32'hFFFFAABB);
    ld(2'b01, 1'b1, 32'h22, 4'b0011, 32'h00001234);
    ld(2'b00, 1'b0, 32'h23, 4'b0001, 32'h00000034);
    ld(2'b11, 1'b0, 32'h20, 4'b1111, 32'hAABB1234);
    // read and write together: the write wins
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h55667788,
          mk(32'hAABB1234, 32'h30, 32'h55667788, 4'b1111, 8'd3, 2'd0, 2'd1, 1'b0, 1'b0));
    ld(2'b10, 1'b0, 32'h30, 4'b1111, 32'h55667788);

    // misaligned requests
    bad(1'b1, 1'b0, 2'b10, 32'h6, 32'h55667788);
    bad(1'b1, 1'b0, 2'b01, 32'h3, 32'h55667788);
    bad(1'b0, 1'b1, 2'b01, 32'h21, 32'h55667788);
    chk("mem_after_bad_sh", mem[8], 32'hAABB1234);

    // no Ack: BusError in the 17th cycle after the request
    ack_off = 1'b1;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0,
          mk(32'h55667788, 32'h8, 32'h0, 4'b1111, 8'd17, 2'd1, 2'd0, 1'b1, 1'b0));
    ack_off = 1'b0;
    @(negedge CLK);
    chk("timeout_back_to_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("timeout_bus_error_clear", {31'd0, BusError}, 32'd0);
    @(posedge CLK);
    #1;

    // reset while a load is waiting
    MemRead = 1'b1; Size = 2'b10; Unsigned = 1'b0; Address = 32'h8; DataIn = 32'h0;
    @(posedge CLK);
    #1;
    chk("abort_in_req", {30'd0, dbg_state}, {30'd0, ST_REQ});
    @(posedge CLK);
    #1;
    chk("abort_in_wait", {30'd0, dbg_state}, {30'd0, ST_WAIT});
    RST = 1'b1; MemRead = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_stall", {31'd0, Stall}, 32'd0);
    chk("abort_data_out", DataOut, 32'h0);
    chk("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("abort_enables", {30'd0, M_WriteEnable, M_ReadEnable}, 32'd0);
    @(posedge CLK);
    #1;
    ld(2'b10, 1'b0, 32'h8, 4'b1111, 32'hDEADBEEF);

    repeat (2) @(posedge CLK);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
